// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C command arbiter.
//   state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   cmd_t   : one register-write command (7-bit device, 16-bit address, 8-bit data)
//   DEV_ID  : default device ID for this board's I2C target
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [6:0]  dev;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  localparam logic [6:0] DEV_ID = 7'h35;

endpackage

// File: rtl/i2c_cmd_arbiter_rr.sv
// rr_arbiter: combinational round-robin selector.
// Ports:
//   req   [NREQ-1:0] in  : pending requests
//   ptr   [IW-1:0]   in  : index of the last granted requester
//   grant [NREQ-1:0] out : one-hot grant (all zero when no request)
//   index [IW-1:0]   out : binary index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   index
);

  // Scan from ptr+1 around to ptr itself; the first pending request wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C register-write engine among NREQ requesters.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]    : per-requester request handshake
//   req_dev/req_addr/req_data     : packed per-requester command fields
//   rsp_valid/rsp_err [NREQ]      : one-cycle completion pulse and error flag
//   eng_valid/eng_ready           : command handshake to the write engine
//   eng_dev/eng_addr/eng_data     : registered command fields to the engine
//   eng_done/eng_nak              : engine completion pulse and NAK flag
//   eng_abort                     : one-cycle pulse forcing the engine idle
//   busy                          : high whenever a transaction is in flight
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [7*NREQ-1:0] req_dev,
  input  logic [16*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ-1:0]   rsp_err,
  output logic              eng_valid,
  input  logic              eng_ready,
  output logic [6:0]        eng_dev,
  output logic [15:0]       eng_addr,
  output logic [7:0]        eng_data,
  input  logic              eng_done,
  input  logic              eng_nak,
  output logic              eng_abort,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  cmd_t            cmd_q, cmd_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_index;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .index (arb_index)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = '0;
    eng_valid = 1'b0;
    eng_abort = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready     = arb_grant;
          ptr_d         = arb_index;
          gnt_d         = arb_index;
          cmd_d.dev     = req_dev[int'(arb_index)*7 +: 7];
          cmd_d.addr    = req_addr[int'(arb_index)*16 +: 16];
          cmd_d.data    = req_data[int'(arb_index)*8 +: 8];
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_valid = 1'b1;
        if (eng_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion in the same cycle as the timeout wins over the abort.
        if (eng_done) begin
          err_d   = eng_nak;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          eng_abort = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_err[gnt_q]   = err_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Keep every handshake quiet while reset is held so a reset mid-transaction
    // never leaks a response, abort or grant.
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = '0;
      eng_valid = 1'b0;
      eng_abort = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      gnt_q   <= '0;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign eng_dev  = cmd_q.dev;
  assign eng_addr = cmd_q.addr;
  assign eng_data = cmd_q.data;
  assign busy     = (state_q != ST_IDLE) && !reset;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: directed self-checking bench for i2c_cmd_arbiter
// (NREQ=3, TIMEOUT=16). Inputs change 1 time unit after the rising edge and
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_i2c_cmd_arbiter;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_ready, rsp_valid, rsp_err;
  logic [20:0] req_dev;
  logic [47:0] req_addr;
  logic [23:0] req_data;
  logic        eng_valid, eng_ready, eng_done, eng_nak, eng_abort, busy;
  logic [6:0]  eng_dev;
  logic [15:0] eng_addr;
  logic [7:0]  eng_data;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dev   (req_dev),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .eng_valid (eng_valid),
    .eng_ready (eng_ready),
    .eng_dev   (eng_dev),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .eng_done  (eng_done),
    .eng_nak   (eng_nak),
    .eng_abort (eng_abort),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic rdy, input logic done, input logic nak);
    req_valid = valid;
    eng_ready = rdy;
    eng_done  = done;
    eng_nak   = nak;
    #1;
  endtask

  task automatic setReq(input int i, input logic [6:0] d, input logic [15:0] a, input logic [7:0] x);
    req_dev[i*7 +: 7]   = d;
    req_addr[i*16 +: 16] = a;
    req_data[i*8 +: 8]  = x;
  endtask

  // One complete transaction starting in IDLE: grant g, engine accepts at once,
  // completes one cycle into WAIT with the given NAK flag.
  task automatic runTxn(input string tag, input logic [2:0] v_grant, input logic [2:0] v_after,
                        input int g, input logic nak, input logic [30:0] ecmd);
    applyStimulus(v_grant, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_ready"}, req_ready, 32'(1 << g));
    nextCycle();
    applyStimulus(v_after, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_issue_ready"}, req_ready, 0);
    checkOutput({tag, "_eng_valid"}, eng_valid, 1);
    checkOutput({tag, "_eng_cmd"}, {eng_dev, eng_addr, eng_data}, ecmd);
    nextCycle();
    applyStimulus(v_after, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_wait_valid"}, eng_valid, 0);
    checkOutput({tag, "_wait_ready"}, req_ready, 0);
    nextCycle();
    applyStimulus(v_after, 1'b0, 1'b1, nak);
    nextCycle();
    applyStimulus(v_after, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 32'(1 << g));
    checkOutput({tag, "_rsp_err"}, rsp_err, nak ? 32'(1 << g) : 0);
    checkOutput({tag, "_rsp_ready"}, req_ready, 0);
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_dev   = '0;
    req_addr  = '0;
    req_data  = '0;
    eng_ready = 1'b0;
    eng_done  = 1'b0;
    eng_nak   = 1'b0;
    nextCycle();
    nextCycle();

    // Reset state, with requests pending that must not be acknowledged.
    applyStimulus(3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_eng_valid", eng_valid, 0);
    checkOutput("rst_eng_abort", eng_abort, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_err}, 0);
    checkOutput("rst_eng_cmd", {eng_dev, eng_addr, eng_data}, 0);
    reset = 1'b0;

    // Single request from requester 1, dropped right after the grant.
    setReq(1, 7'h35, 16'h0103, 8'h01);
    runTxn("single", 3'b010, 3'b000, 1, 1'b0, {7'h35, 16'h0103, 8'h01});
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("single_idle_busy", busy, 0);
    checkOutput("single_idle_rsp", rsp_valid, 0);

    // Fresh reset, then all three requesting: order 0,1,2,0; NAK on requester 1.
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    setReq(0, 7'h10, 16'h1000, 8'hA0);
    setReq(1, 7'h11, 16'h1111, 8'hA1);
    setReq(2, 7'h12, 16'h2222, 8'hA2);
    runTxn("rr0", 3'b111, 3'b111, 0, 1'b0, {7'h10, 16'h1000, 8'hA0});
    runTxn("rr1_nak", 3'b111, 3'b111, 1, 1'b1, {7'h11, 16'h1111, 8'hA1});
    runTxn("rr2", 3'b111, 3'b111, 2, 1'b0, {7'h12, 16'h2222, 8'hA2});
    runTxn("rr0b", 3'b111, 3'b111, 0, 1'b0, {7'h10, 16'h1000, 8'hA0});

    // Requester 2 alone; engine stalls 50 cycles in ISSUE, then never completes.
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_ready", req_ready, 3'b100);
    nextCycle();
    setReq(2, 7'h7F, 16'hFFFF, 8'hFF);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(3'b000, 1'b0, i == 10, i == 10);
      checkOutput("stall_hold", {eng_valid, eng_dev, eng_addr, eng_data}, {1'b1, 7'h12, 16'h2222, 8'hA2});
      nextCycle();
    end
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_accept_valid", eng_valid, 1);
    nextCycle();
    for (int k = 0; k < TIMEOUT; k++) begin
      applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("tmo_no_early_abort", eng_abort, 0);
      nextCycle();
    end
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_abort", eng_abort, 1);
    nextCycle();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_rsp_valid", rsp_valid, 3'b100);
    checkOutput("tmo_rsp_err", rsp_err, 3'b100);
    checkOutput("tmo_abort_once", eng_abort, 0);
    nextCycle();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_idle_busy", busy, 0);

    // Requester 0: eng_done lands exactly on the timeout cycle and wins.
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
    checkOutput("race_ready", req_ready, 3'b001);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    nextCycle();
    for (int k = 0; k < TIMEOUT; k++) begin
      applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(3'b000, 1'b0, 1'b1, 1'b0);
    checkOutput("race_no_abort", eng_abort, 0);
    nextCycle();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("race_rsp_valid", rsp_valid, 3'b001);
    checkOutput("race_rsp_err", rsp_err, 3'b000);
    nextCycle();

    // Requester 1 granted, reset asserted while waiting on the engine.
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_ready", req_ready, 3'b010);
    nextCycle();
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(3'b011, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_rst_rsp", rsp_valid, 0);
    checkOutput("mid_rst_abort", eng_abort, 0);
    nextCycle();
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_eng_valid", eng_valid, 0);
    checkOutput("mid_rst_eng_cmd", {eng_dev, eng_addr, eng_data}, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    reset = 1'b0;
    applyStimulus(3'b011, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_grant0", req_ready, 3'b001);
    nextCycle();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_cmd", {eng_valid, eng_dev, eng_addr, eng_data}, {1'b1, 7'h10, 16'h1000, 8'hA0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
